// File: rtl/ibex_trace_pkg.sv
// Shared types for the RVFI trace streamer: the captured record, header bit
// positions and the serialiser word sequence.
package ibex_trace_pkg;

    typedef struct packed {
        logic [15:0] order;
        logic        trap;
        logic        intr;
        logic        halt;
        logic [1:0]  mode;
        logic [4:0]  rd_addr;
        logic        mem;
        logic        ovf;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
    } trace_rec_t;

    localparam int unsigned HdrOrderLsb = 16;
    localparam int unsigned HdrTrapBit  = 15;
    localparam int unsigned HdrIntrBit  = 14;
    localparam int unsigned HdrHaltBit  = 13;
    localparam int unsigned HdrModeLsb  = 11;
    localparam int unsigned HdrRdLsb    = 6;
    localparam int unsigned HdrMemBit   = 5;
    localparam int unsigned HdrOvfBit   = 4;

    typedef enum logic [2:0] {
        WordHdr,
        WordPc,
        WordInsn,
        WordWdata,
        WordMem
    } trace_word_e;

    // Bits [3:0] of the header are reserved and always zero.
    function automatic logic [31:0] pack_header(input trace_rec_t rec);
        logic [31:0] hdr;
        hdr                      = '0;
        hdr[HdrOrderLsb +: 16]   = rec.order;
        hdr[HdrTrapBit]          = rec.trap;
        hdr[HdrIntrBit]          = rec.intr;
        hdr[HdrHaltBit]          = rec.halt;
        hdr[HdrModeLsb +: 2]     = rec.mode;
        hdr[HdrRdLsb +: 5]       = rec.rd_addr;
        hdr[HdrMemBit]           = rec.mem;
        hdr[HdrOvfBit]           = rec.ovf;
        return hdr;
    endfunction

endpackage

// File: rtl/prim_fifo_sync.sv
// Synchronous FIFO with registered occupancy. Pass=1 lets a write bypass an
// empty FIFO straight to the read side.
module prim_fifo_sync #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 8,
    parameter bit          Pass  = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wvalid_i,
    output logic                     wready_o,
    input  logic [Width-1:0]         wdata_i,
    output logic                     rvalid_o,
    input  logic                     rready_i,
    output logic [Width-1:0]         rdata_o,
    output logic [$clog2(Depth):0]   depth_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] FullLevel = (PtrW + 1)'(Depth);

    logic [Width-1:0] storage_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [PtrW:0]    depth_q, depth_d;
    logic             empty, push, pop;

    assign empty    = (depth_q == '0);
    assign wready_o = (depth_q != FullLevel);
    assign rvalid_o = !empty || (Pass && wvalid_i);
    assign rdata_o  = (Pass && empty) ? wdata_i : storage_q[rptr_q];
    assign push     = wvalid_i && wready_o && !(Pass && empty && rready_i);
    assign pop      = rvalid_o && rready_i && !empty;
    assign depth_o  = depth_q;
    assign depth_d  = depth_q + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            depth_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PtrW'(1);
            if (pop)  rptr_q <= rptr_q + PtrW'(1);
            depth_q <= depth_d;
        end
    end

    // NOTE: storage is deliberately not reset; the occupancy count guarantees
    // stale entries are never read, and unreset arrays map to plain RAM.
    always_ff @(posedge clk_i) begin
        if (push) storage_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ibex_rvfi_trace_streamer.sv
// Captures RVFI retirements into a record FIFO and serialises each record as
// 4 or 5 32-bit words on a valid/ready stream, counting dropped records.
module ibex_rvfi_trace_streamer
    import ibex_trace_pkg::*;
#(
    parameter int unsigned Depth        = 8,
    parameter int unsigned DropCntWidth = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      trace_en_i,
    input  logic                      rvfi_valid,
    input  logic [63:0]               rvfi_order,
    input  logic [31:0]               rvfi_insn,
    input  logic                      rvfi_trap,
    input  logic                      rvfi_halt,
    input  logic                      rvfi_intr,
    input  logic [1:0]                rvfi_mode,
    input  logic [4:0]                rvfi_rd_addr,
    input  logic [31:0]               rvfi_rd_wdata,
    input  logic [31:0]               rvfi_pc_rdata,
    input  logic [31:0]               rvfi_mem_addr,
    input  logic [3:0]                rvfi_mem_rmask,
    input  logic [3:0]                rvfi_mem_wmask,
    output logic                      trace_valid_o,
    input  logic                      trace_ready_i,
    output logic [31:0]               trace_data_o,
    output logic                      trace_last_o,
    output logic [DropCntWidth-1:0]   drop_cnt_o,
    output logic [$clog2(Depth):0]    fifo_level_o
);

    trace_rec_t              wr_rec, head;
    trace_word_e             state_q, state_d;
    logic [DropCntWidth-1:0] drop_cnt_q;
    logic                    ovf_q;
    logic                    capture, fifo_ready, push, drop, hs, pop, last;
    logic [31:0]             word;
    logic                    unused_order;

    assign unused_order = ^rvfi_order[63:16];

    assign capture = rvfi_valid && trace_en_i;
    assign push    = capture && fifo_ready;
    assign drop    = capture && !fifo_ready;

    always_comb begin
        wr_rec          = '0;
        wr_rec.order    = rvfi_order[15:0];
        wr_rec.trap     = rvfi_trap;
        wr_rec.intr     = rvfi_intr;
        wr_rec.halt     = rvfi_halt;
        wr_rec.mode     = rvfi_mode;
        wr_rec.rd_addr  = rvfi_rd_addr;
        wr_rec.mem      = |(rvfi_mem_rmask | rvfi_mem_wmask);
        wr_rec.ovf      = ovf_q;
        wr_rec.pc       = rvfi_pc_rdata;
        wr_rec.insn     = rvfi_insn;
        wr_rec.rd_wdata = rvfi_rd_wdata;
        wr_rec.mem_addr = rvfi_mem_addr;
    end

    prim_fifo_sync #(
        .Width ($bits(trace_rec_t)),
        .Depth (Depth),
        .Pass  (1'b0)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .wvalid_i (push),
        .wready_o (fifo_ready),
        .wdata_i  (wr_rec),
        .rvalid_o (trace_valid_o),
        .rready_i (pop),
        .rdata_o  (head),
        .depth_o  (fifo_level_o)
    );

    assign hs  = trace_valid_o && trace_ready_i;
    assign pop = hs && last;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        word    = '0;
        last    = 1'b0;
        unique case (state_q)
            WordHdr: begin
                word = pack_header(head);
                if (hs) state_d = WordPc;
            end
            WordPc: begin
                word = head.pc;
                if (hs) state_d = WordInsn;
            end
            WordInsn: begin
                word = head.insn;
                if (hs) state_d = WordWdata;
            end
            WordWdata: begin
                word = head.rd_wdata;
                last = !head.mem;
                if (hs) state_d = head.mem ? WordMem : WordHdr;
            end
            WordMem: begin
                word = head.mem_addr;
                last = 1'b1;
                if (hs) state_d = WordHdr;
            end
            default: state_d = WordHdr;
        endcase
    end

    assign trace_data_o = trace_valid_o ? word : '0;
    assign trace_last_o = trace_valid_o && last;
    assign drop_cnt_o   = drop_cnt_q;

    // The overflow flag marks the first record accepted after any loss.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= WordHdr;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + DropCntWidth'(1);
            if (drop)      ovf_q <= 1'b1;
            else if (push) ovf_q <= 1'b0;
        end
    end

endmodule

// File: doc/ibex_rvfi_trace_streamer.md
Name: ibex_rvfi_trace_streamer

Overview:
- Downstream consumer of the core's RVFI retirement port; sits beside the simulation tracer in the tracing top.
- Captures each retired instruction into a record FIFO.
- Serialises each record onto a 32-bit valid/ready stream for an off-core trace sink (DMA, debug port, trace RAM).
- Unlike the simulation-only tracer, it is synthesisable and reports dropped records.

Parameters:
- Depth, 8: record FIFO depth; power of two, >=2.
- DropCntWidth, 16: width of the saturating drop counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- trace_en_i  in  1  capture enable
- rvfi_valid  in  1  instruction retired this cycle
- rvfi_order  in  64  retirement index
- rvfi_insn  in  32  instruction word
- rvfi_trap  in  1  trap taken
- rvfi_halt  in  1  halt
- rvfi_intr  in  1  first instruction of a handler
- rvfi_mode  in  2  privilege mode
- rvfi_rd_addr  in  5  destination register
- rvfi_rd_wdata  in  32  destination write data
- rvfi_pc_rdata  in  32  PC of the retired instruction
- rvfi_mem_addr  in  32  memory access address
- rvfi_mem_rmask  in  4  read byte mask
- rvfi_mem_wmask  in  4  write byte mask
- trace_valid_o  out  1  stream word valid
- trace_ready_i  in  1  sink ready
- trace_data_o  out  32  stream word
- trace_last_o  out  1  last word of the current record
- drop_cnt_o  out  DropCntWidth  records dropped, saturating
- fifo_level_o  out  $clog2(Depth)+1  records currently held

Behaviour:
- Clocking/reset: single clock clk_i; rst_ni is asynchronous, active-low.
- Reset values: FIFO empty; word index 0; overflow flag 0; trace_valid_o=0, trace_last_o=0, trace_data_o=0, drop_cnt_o=0, fifo_level_o=0.
- Capture: rvfi_valid && trace_en_i && !full -> record written at the end of cycle N.
- Capture latency: that record is presented with trace_valid_o=1 in cycle N+1 when the FIFO was empty.
- Full check: uses the registered level. A pop in the same cycle does NOT free a slot for that cycle's write.
- Drop: rvfi_valid && trace_en_i && full -> record dropped.
  - drop_cnt_o increments, saturating at all-ones.
  - Pending overflow flag is set.
- Overflow flag: the next accepted record carries header bit 4 = 1, and the flag clears on that write. A drop and a write cannot coincide.
- Disabled: rvfi_valid && !trace_en_i -> ignored, not counted. Records already in the FIFO keep draining.
- Record capture fields: order[15:0], trap, intr, halt, mode, rd_addr, mem = |(rmask|wmask), pc, insn, rd_wdata, mem_addr, ovf flag.
- Words per record, in order:
  - W0 header: [31:16] order[15:0], [15] trap, [14] intr, [13] halt, [12:11] mode, [10:6] rd_addr, [5] mem, [4] ovf, [3:0] 0.
  - W1 pc_rdata.
  - W2 insn.
  - W3 rd_wdata.
  - W4 mem_addr, only if mem=1.
- Serialiser FSM, states HDR -> PC -> INSN -> WDATA -> MEM:
  - A state advances only on trace_valid_o && trace_ready_i.
  - WDATA returns to HDR when mem=0; MEM returns to HDR.
  - The FIFO pops on the handshake of the last word.
- trace_last_o: high during WDATA when mem=0, and during MEM.
- Output timing: trace_valid_o = FIFO non-empty. trace_data_o is combinational from the FIFO head and the state, and is 0 when the FIFO is empty.
- Stream hold rule: while trace_valid_o && !trace_ready_i, trace_data_o and trace_last_o stay stable.
- Back-to-back records: after the last-word handshake, HDR of the next record is presented the following cycle with no bubble. A simultaneous write and pop leaves the level unchanged.
- Reset mid-record: the partial record is discarded and all state returns to reset values immediately.

Decomposition:
- Package ibex_trace_pkg:
  - trace_rec_t packed struct.
  - Header bit-position localparams.
  - trace_word_e enum for the serialiser states.
- Sub-module: prim_fifo_sync with Width=$bits(trace_rec_t), Depth=Depth, Pass=0; its depth output drives fifo_level_o.
- Serialiser FSM and drop logic live in the top module.

Test Plan:
- Single ALU retirement, trace_ready_i=1:
  - Stimulus: pc=0x80, insn=0x00500093, rd=1, wdata=5, order=3.
  - Response: 4 words in cycles N+1..N+4 = 0x00030040, 0x80, 0x00500093, 5; last on word 4.
- Store retirement:
  - Stimulus: wmask=4'hF, mem_addr=0x1000.
  - Response: 5 words; header bit5=1; W4=0x1000 with last=1.
- Overflow, Depth=8, trace_ready_i=0:
  - Stimulus: 10 retirements.
  - Response: fifo_level_o=8, drop_cnt_o=2.
  - Then raise ready and retire 1 more: the 9th record output has header bit4=1; records 1-8 have bit4=0.
- Backpressure:
  - Stimulus: toggle trace_ready_i randomly.
  - Response: data/last stable while stalled; word order intact; no bubble between records when ready stays 1.
- Enable and reset:
  - Stimulus: trace_en_i=0 with 3 retirements.
  - Response: no output, drop_cnt_o=0.
  - Then assert rst_ni low in the middle of word W2: all outputs 0 asynchronously; after release, fifo_level_o=0.
